// File: rtl/sump_cmd_parser.sv
// -----------------------------------------------------------------------------
// sump_cmd_parser
//
// Assembles SUMP logic-analyser commands from a stream of UART bytes.
// A byte with bit 7 clear is a complete one-byte (short) command. A byte with
// bit 7 set is the opcode of a long command and is followed by four payload
// bytes, shifted in MSB-first. A finished command is held on the cmd_* outputs
// with cmd_valid high until the consumer takes it with cmd_ready.
//
// Optional feature (macro SUMP_CMD_TIMEOUT_EN):
//   When defined, a partial long command is abandoned if no payload byte
//   arrives within TIMEOUT_CYCLES clocks. timeout_err pulses when that happens.
//   When undefined, there is no counter, timeout_err is tied low, and a
//   partial long command waits for its payload indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  inter-byte idle limit in clocks (10 ms at 100 MHz)
//
// Ports:
//   system_clock  in   1   single clock, rising edge
//   reset         in   1   synchronous, active-high
//   rx_data       in   8   byte from UART receiver
//   rx_valid      in   1   one-cycle strobe qualifying rx_data
//   cmd_opcode    out  8   opcode of the held command
//   cmd_data      out  32  long-command payload, zero for short commands
//   cmd_is_long   out  1   opcode bit 7
//   cmd_valid     out  1   command presented (HOLD state)
//   cmd_ready     in   1   consumer accept; transfer = cmd_valid & cmd_ready
//   overflow_err  out  1   one-cycle pulse when a byte is dropped in HOLD
//   timeout_err   out  1   one-cycle pulse when a partial command is aborted
// -----------------------------------------------------------------------------
module sump_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        cmd_is_long,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        overflow_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] data_q, data_d;
  logic        is_long_q, is_long_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        tmo_err_q, tmo_err_d;
  logic        take_opcode;
  logic        tmo_expired;

`ifdef SUMP_CMD_TIMEOUT_EN
  // The counter only has to reach TIMEOUT_CYCLES-1; expiry leaves COLLECT,
  // so it never needs to wrap.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Held at zero outside COLLECT so it starts from zero on every entry, and
  // cleared by every byte received while collecting.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != COLLECT || rx_valid) begin
      tmo_d = '0;
    end else if (!tmo_expired) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // A byte on the expiry cycle wins: expiry requires rx_valid low.
  assign tmo_expired = (state_q == COLLECT) && !rx_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge system_clock) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_expired = 1'b0;

  // Parameter kept for a uniform interface; it has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    data_d      = data_q;
    is_long_d   = is_long_q;
    cnt_d       = cnt_q;
    ovf_d       = 1'b0;
    tmo_err_d   = 1'b0;
    take_opcode = 1'b0;

    case (state_q)
      IDLE: begin
        take_opcode = rx_valid;
      end

      COLLECT: begin
        if (rx_valid) begin
          data_d = {data_q[23:0], rx_data};
          if (cnt_q == 2'd3) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_expired) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
      end

      HOLD: begin
        if (cmd_ready) begin
          // Transfer this cycle; a coincident byte starts the next command
          // straight away instead of being dropped.
          state_d     = IDLE;
          take_opcode = rx_valid;
        end else if (rx_valid) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Opcode capture shared by IDLE and the transfer cycle in HOLD.
    if (take_opcode) begin
      opcode_d  = rx_data;
      data_d    = '0;
      cnt_d     = '0;
      is_long_d = rx_data[7];
      state_d   = rx_data[7] ? COLLECT : HOLD;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      data_q    <= '0;
      is_long_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      data_q    <= data_d;
      is_long_q <= is_long_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign cmd_valid    = (state_q == HOLD);
  assign cmd_opcode   = opcode_q;
  assign cmd_data     = data_q;
  assign cmd_is_long  = is_long_q;
  assign overflow_err = ovf_q;
  assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_sump_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_sump_cmd_parser
//
// Directed bench for sump_cmd_parser. Expected commands are pushed to a
// scoreboard queue as bytes are sent; a monitor pops and compares on every
// transfer, checks held outputs stay stable, and counts error pulses.
// Timeout behaviour is checked according to SUMP_CMD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_sump_cmd_parser;

  localparam int TMO = 40;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        cmd_is_long;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        overflow_err;
  logic        timeout_err;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
    logic        lng;
  } cmd_t;

  cmd_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int ovf_cnt  = 0;
  int tmo_cnt  = 0;

  sump_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .system_clock (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .cmd_opcode   (cmd_opcode),
    .cmd_data     (cmd_data),
    .cmd_is_long  (cmd_is_long),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, ending 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] d, input logic lng);
    cmd_t e;
    e.op   = op;
    e.data = d;
    e.lng  = lng;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
    check(tag, sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_opcode"}, cmd_opcode, 0);
    check({tag, "_data"}, cmd_data, 0);
    check({tag, "_is_long"}, cmd_is_long, 0);
    check({tag, "_ovf"}, overflow_err, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic        prev_hold;
    logic [7:0]  held_op;
    logic [31:0] held_data;
    logic        held_lng;
    logic        ovf_prev;
    logic        tmo_prev;
    cmd_t        e;
    prev_hold = 1'b0;
    ovf_prev  = 1'b0;
    tmo_prev  = 1'b0;
    held_op   = '0;
    held_data = '0;
    held_lng  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (cmd_valid && prev_hold) begin
          check("hold_stable_op", cmd_opcode, held_op);
          check("hold_stable_data", cmd_data, held_data);
          check("hold_stable_long", cmd_is_long, held_lng);
        end
        if (cmd_valid && cmd_ready) begin
          xfer_cnt++;
          $display("xfer %0d: op=0x%02h data=0x%08h long=%0d", xfer_cnt, cmd_opcode, cmd_data, cmd_is_long);
          if (sb.size() == 0) begin
            // Nothing was expected: report the stray opcode.
            check("unexpected_cmd_op", cmd_opcode, 32'h100);
          end else begin
            e = sb.pop_front();
            check("xfer_op", cmd_opcode, e.op);
            check("xfer_data", cmd_data, e.data);
            check("xfer_long", cmd_is_long, e.lng);
          end
        end
        if (overflow_err) begin
          ovf_cnt++;
          check("ovf_pulse_width", ovf_prev, 0);
        end
        if (timeout_err) begin
          tmo_cnt++;
          check("tmo_pulse_width", tmo_prev, 0);
        end
        prev_hold = cmd_valid && !cmd_ready;
        held_op   = cmd_opcode;
        held_data = cmd_data;
        held_lng  = cmd_is_long;
      end
      ovf_prev = overflow_err;
      tmo_prev = timeout_err;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int o;

    // Reset, with a byte presented during reset that must be discarded.
    reset     = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = 8'h05;
    cmd_ready = 1'b1;
    tick(3);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check_zero_outputs("reset");
    tick(3);
    check("reset_byte_dropped", cmd_valid, 0);
    check("reset_no_xfer", xfer_cnt, 0);

    // Short command 0x04, consumer always ready.
    c = xfer_cnt;
    expect_cmd(8'h04, 32'h0, 1'b0);
    send_byte(8'h04);
    check("short_valid_rise", cmd_valid, 1);
    check("short_op", cmd_opcode, 8'h04);
    tick(1);
    check("short_valid_fall", cmd_valid, 0);
    check("short_xfer_count", xfer_cnt - c, 1);

    // Long command 0x80 + 0x000186A0, back-to-back bytes.
    expect_cmd(8'h80, 32'h000186A0, 1'b1);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h86);
    check("long_not_early", cmd_valid, 0);
    send_byte(8'hA0);
    check("long_valid_rise", cmd_valid, 1);
    check("long_data", cmd_data, 32'h000186A0);
    drain("long_drain");

    // Overflow: 0x02 held, 0x11 dropped.
    cmd_ready = 1'b0;
    expect_cmd(8'h02, 32'h0, 1'b0);
    send_byte(8'h02);
    tick(2);
    o = ovf_cnt;
    send_byte(8'h11);
    check("ovf_pulse", overflow_err, 1);
    tick(1);
    check("ovf_pulse_end", overflow_err, 0);
    check("ovf_held_op", cmd_opcode, 8'h02);
    check("ovf_held_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    drain("ovf_drain");
    tick(3);
    check("ovf_count", ovf_cnt - o, 1);

    // Byte coinciding with the transfer cycle is kept.
    cmd_ready = 1'b0;
    expect_cmd(8'h03, 32'h0, 1'b0);
    send_byte(8'h03);
    tick(1);
    cmd_ready = 1'b1;
    o = ovf_cnt;
    expect_cmd(8'h05, 32'h0, 1'b0);
    send_byte(8'h05);
    check("coincide_valid", cmd_valid, 1);
    check("coincide_op", cmd_opcode, 8'h05);
    drain("coincide_drain");
    check("coincide_no_ovf", ovf_cnt - o, 0);

`ifdef SUMP_CMD_TIMEOUT_EN
    // Partial long command aborted after TMO idle clocks.
    c = tmo_cnt;
    send_byte(8'hC1);
    send_byte(8'h00);
    tick(TMO - 1);
    check("tmo_not_early", timeout_err, 0);
    tick(1);
    check("tmo_pulse", timeout_err, 1);
    tick(1);
    check("tmo_pulse_end", timeout_err, 0);
    check("tmo_count", tmo_cnt - c, 1);
    expect_cmd(8'h01, 32'h0, 1'b0);
    send_byte(8'h01);
    drain("tmo_follow_drain");

    // A byte on the expiry cycle beats the timeout.
    c = tmo_cnt;
    expect_cmd(8'hC2, 32'h0A0B0C0D, 1'b1);
    send_byte(8'hC2);
    tick(TMO - 1);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h0C);
    send_byte(8'h0D);
    drain("tmo_edge_drain");
    check("tmo_edge_no_pulse", tmo_cnt - c, 0);
`else
    // Without the timeout feature, a partial command waits indefinitely.
    expect_cmd(8'hC1, 32'h00010203, 1'b1);
    send_byte(8'hC1);
    send_byte(8'h00);
    tick(TMO + 5);
    check("collect_wait_valid", cmd_valid, 0);
    check("collect_wait_tmo", timeout_err, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    drain("collect_wait_drain");
    check("tmo_never", tmo_cnt, 0);
`endif

    // Five 0x00 bytes with UART-like spacing (scaled down).
    c = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      expect_cmd(8'h00, 32'h0, 1'b0);
      send_byte(8'h00);
      tick(20);
    end
    drain("zero_burst_drain");
    check("zero_burst_count", xfer_cnt - c, 5);

    // Reset during COLLECT.
    o = ovf_cnt;
    c = tmo_cnt;
    send_byte(8'h81);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_zero_outputs("rst_collect");
    tick(2);
    check("rst_collect_no_ovf", ovf_cnt - o, 0);
    check("rst_collect_no_tmo", tmo_cnt - c, 0);
    expect_cmd(8'h01, 32'h0, 1'b0);
    send_byte(8'h01);
    check("rst_follow_op", cmd_opcode, 8'h01);
    drain("rst_follow_drain");

    // Reset during HOLD discards the held command.
    cmd_ready = 1'b0;
    send_byte(8'h07);
    check("rst_hold_pre", cmd_valid, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_zero_outputs("rst_hold");
    cmd_ready = 1'b1;
    tick(3);
    check("rst_hold_no_ovf", ovf_cnt - o, 0);

    check("final_queue_empty", sb.size(), 0);
    check("final_ovf_total", ovf_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
